// File: rtl/ll_arbiter.sv
// Round-robin push/pop arbiter for a shared-element linked list, with shadow occupancy counters.
// Define LL_ARBITER_OCC_EN to expose the packed per-list counts on port occ.
module ll_arbiter #(
    parameter int NUM_ELEMS = 4,
    parameter int NUM_LISTS = 2,
    parameter int CNT_WIDTH = $clog2(NUM_ELEMS) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LISTS-1:0] push_req,
    input  logic [NUM_LISTS-1:0] pop_req,
    output logic [NUM_LISTS-1:0] push,
    output logic [NUM_LISTS-1:0] pop,
    output logic                 full,
    output logic [NUM_LISTS-1:0] empty,
`ifdef LL_ARBITER_OCC_EN
    output logic [NUM_LISTS*CNT_WIDTH-1:0] occ,
`endif
    output logic [CNT_WIDTH-1:0] total
);

    localparam int PTR_W = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1;
    localparam logic [PTR_W-1:0] RR_INIT = PTR_W'(NUM_LISTS - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_VAL = CNT_WIDTH'(NUM_ELEMS);

    logic [PTR_W-1:0]     rr_push_q, rr_push_d;
    logic [PTR_W-1:0]     rr_pop_q, rr_pop_d;
    logic [CNT_WIDTH-1:0] count_q [NUM_LISTS];
    logic [CNT_WIDTH-1:0] count_d [NUM_LISTS];
    logic [CNT_WIDTH-1:0] total_q, total_d;

    logic                 push_found, pop_found;
    logic [PTR_W-1:0]     push_idx, pop_idx;
    logic [NUM_LISTS-1:0] pop_elig;

    always_comb begin
        full = (total_q == FULL_VAL);
        for (int i = 0; i < NUM_LISTS; i++) begin
            empty[i] = (count_q[i] == '0);
        end
    end

    assign total    = total_q;
    assign pop_elig = pop_req & ~empty;

    // Search starts one past the last winner; a blocked side (reset or full) grants nothing.
    always_comb begin
        push       = '0;
        push_found = 1'b0;
        push_idx   = rr_push_q;
        for (int k = 0; k < NUM_LISTS; k++) begin
            if (!push_found && push_req[(int'(rr_push_q) + 1 + k) % NUM_LISTS]) begin
                push[(int'(rr_push_q) + 1 + k) % NUM_LISTS] = 1'b1;
                push_found = 1'b1;
                push_idx   = PTR_W'((int'(rr_push_q) + 1 + k) % NUM_LISTS);
            end
        end
        if (!rst || full) begin
            push       = '0;
            push_found = 1'b0;
            push_idx   = rr_push_q;
        end
    end

    always_comb begin
        pop       = '0;
        pop_found = 1'b0;
        pop_idx   = rr_pop_q;
        for (int k = 0; k < NUM_LISTS; k++) begin
            if (!pop_found && pop_elig[(int'(rr_pop_q) + 1 + k) % NUM_LISTS]) begin
                pop[(int'(rr_pop_q) + 1 + k) % NUM_LISTS] = 1'b1;
                pop_found = 1'b1;
                pop_idx   = PTR_W'((int'(rr_pop_q) + 1 + k) % NUM_LISTS);
            end
        end
        if (!rst) begin
            pop       = '0;
            pop_found = 1'b0;
            pop_idx   = rr_pop_q;
        end
    end

    always_comb begin
        rr_push_d = push_found ? push_idx : rr_push_q;
        rr_pop_d  = pop_found ? pop_idx : rr_pop_q;
        total_d   = total_q + CNT_WIDTH'(|push) - CNT_WIDTH'(|pop);
        for (int i = 0; i < NUM_LISTS; i++) begin
            count_d[i] = count_q[i] + CNT_WIDTH'(push[i]) - CNT_WIDTH'(pop[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_push_q <= RR_INIT;
            rr_pop_q  <= RR_INIT;
            total_q   <= '0;
            for (int i = 0; i < NUM_LISTS; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            rr_push_q <= rr_push_d;
            rr_pop_q  <= rr_pop_d;
            total_q   <= total_d;
            for (int i = 0; i < NUM_LISTS; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

`ifdef LL_ARBITER_OCC_EN
    always_comb begin
        occ = '0;
        for (int i = 0; i < NUM_LISTS; i++) begin
            occ[CNT_WIDTH*i +: CNT_WIDTH] = count_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_ll_arbiter.sv
// Randomized and directed bench for ll_arbiter against a queue-free occupancy model.
module tb_ll_arbiter;

    localparam int NE = 4;
    localparam int NL = 2;
    localparam int CW = $clog2(NE) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NL-1:0] push_req = '0;
    logic [NL-1:0] pop_req = '0;
    logic [NL-1:0] push, pop, empty;
    logic          full;
    logic [CW-1:0] total;
`ifdef LL_ARBITER_OCC_EN
    logic [NL*CW-1:0] occ;
`endif

    ll_arbiter #(.NUM_ELEMS(NE), .NUM_LISTS(NL), .CNT_WIDTH(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .push_req (push_req),
        .pop_req  (pop_req),
        .push     (push),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
`ifdef LL_ARBITER_OCC_EN
        .occ      (occ),
`endif
        .total    (total)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_cnt [NL];
    int m_tot;
    int m_rr_push, m_rr_pop;
    int last_push_idx, last_pop_idx;
    logic [NL-1:0] last_push, last_pop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int rr, input logic [NL-1:0] elig);
        for (int k = 0; k < NL; k++) begin
            if (elig[(rr + 1 + k) % NL]) return (rr + 1 + k) % NL;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) m_cnt[i] = 0;
        m_tot     = 0;
        m_rr_push = NL - 1;
        m_rr_pop  = NL - 1;
    endtask

    task automatic check_state(input string tag);
        logic [NL-1:0] e_empty;
        for (int i = 0; i < NL; i++) e_empty[i] = (m_cnt[i] == 0);
        check({tag, "_total"}, 32'(total), 32'(m_tot));
        check({tag, "_full"}, 32'(full), 32'(m_tot == NE));
        check({tag, "_empty"}, 32'(empty), 32'(e_empty));
`ifdef LL_ARBITER_OCC_EN
        for (int i = 0; i < NL; i++) begin
            check({tag, "_occ"}, 32'(occ[CW*i +: CW]), 32'(m_cnt[i]));
        end
`endif
    endtask

    // One cycle: drive at negedge, check grants and state, then advance the model at the edge.
    task automatic step(input logic [NL-1:0] pr, input logic [NL-1:0] qr);
        logic [NL-1:0] pop_elig;
        logic [NL-1:0] e_push, e_pop;
        @(negedge clk);
        push_req = pr;
        pop_req  = qr;
        #1;
        for (int i = 0; i < NL; i++) pop_elig[i] = qr[i] && (m_cnt[i] > 0);
        last_push_idx = (m_tot == NE) ? -1 : pick(m_rr_push, pr);
        last_pop_idx  = pick(m_rr_pop, pop_elig);
        e_push = '0;
        e_pop  = '0;
        if (last_push_idx >= 0) e_push[last_push_idx] = 1'b1;
        if (last_pop_idx >= 0) e_pop[last_pop_idx] = 1'b1;
        last_push = push;
        last_pop  = pop;
        check("push", 32'(push), 32'(e_push));
        check("pop", 32'(pop), 32'(e_pop));
        check_state("pre");
        @(posedge clk);
        if (last_push_idx >= 0) begin
            m_cnt[last_push_idx]++;
            m_tot++;
            m_rr_push = last_push_idx;
        end
        if (last_pop_idx >= 0) begin
            m_cnt[last_pop_idx]--;
            m_tot--;
            m_rr_pop = last_pop_idx;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_push", 32'(push), 32'(0));
        check("rst_pop", 32'(pop), 32'(0));
        check_state("rst");
        push_req = '0;
        pop_req  = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        check("por_push", 32'(push), 32'(0));
        check_state("por");
        @(negedge clk);
        rst = 1'b1;

        // Both requesters push: index 0 first, then 1.
        step(2'b11, 2'b00);
        check("d1_push0", 32'(last_push), 32'(2'b01));
        step(2'b11, 2'b00);
        check("d1_push1", 32'(last_push), 32'(2'b10));
        @(negedge clk);
        push_req = '0;
        #1;
        check("d1_total", 32'(total), 32'(2));
        check("d1_empty", 32'(empty), 32'(2'b00));

        // Fill list 0, then push is refused until a pop frees space.
        do_reset();
        for (int n = 0; n < 5; n++) step(2'b01, 2'b00);
        check("d2_blocked", 32'(last_push), 32'(2'b00));
        check("d2_full", 32'(full), 32'(1));
        check("d2_total", 32'(total), 32'(4));
        step(2'b01, 2'b01);
        check("d3_pop", 32'(last_pop), 32'(2'b01));
        check("d3_push", 32'(last_push), 32'(2'b00));
        step(2'b01, 2'b00);
        check("d3_repush", 32'(last_push), 32'(2'b01));

        // Pop from an empty list is skipped in favour of the next eligible one.
        do_reset();
        step(2'b10, 2'b00);
        step(2'b10, 2'b00);
        step(2'b00, 2'b11);
        check("d4_pop", 32'(last_pop), 32'(2'b10));
        @(negedge clk);
        pop_req = '0;
        #1;
        check("d4_empty", 32'(empty), 32'(2'b01));

        // Simultaneous push and pop on the same list.
        do_reset();
        step(2'b01, 2'b00);
        step(2'b01, 2'b01);
        check("d5_push", 32'(last_push), 32'(2'b01));
        check("d5_pop", 32'(last_pop), 32'(2'b01));
        @(negedge clk);
        push_req = '0;
        pop_req  = '0;
        #1;
        check("d5_total", 32'(total), 32'(1));

        // Reset asserted while a push grant is live.
        @(negedge clk);
        push_req = 2'b01;
        #1;
        check("d6_pre", 32'(push), 32'(2'b01));
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        check("d6_push", 32'(push), 32'(2'b00));
        check_state("d6");
        @(negedge clk);
        push_req = '0;
        rst = 1'b1;

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            step(NL'($urandom_range(0, 3)), NL'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ll_arbiter.md
LL_ARBITER -- requirements
Module: ll_arbiter

Interface
REQ-001 Parameter NUM_ELEMS, default 4: total shared elements in the downstream linked_list.
REQ-002 Parameter NUM_LISTS, default 2: number of lists, equal to the number of requester ports.
REQ-003 Parameter CNT_WIDTH, default $clog2(NUM_ELEMS)+1: occupancy counter width.
REQ-004 Ports SHALL be:
  clk  in  1  single clock, rising edge.
  rst  in  1  reset, asynchronous, active-low.
  push_req  in  NUM_LISTS  bit i: requester i wants one push onto list i.
  pop_req  in  NUM_LISTS  bit i: requester i wants one pop from list i.
  push  out  NUM_LISTS  zero/one-hot push command to linked_list; doubles as push grant.
  pop  out  NUM_LISTS  zero/one-hot pop command to linked_list; doubles as pop grant.
  full  out  1  shadow total occupancy == NUM_ELEMS.
  empty  out  NUM_LISTS  bit i: shadow count of list i == 0.
  total  out  CNT_WIDTH  shadow total occupancy.

Function
REQ-005 Push and pop SHALL be arbitrated independently, each by its own round-robin pointer (rr_push, rr_pop).
REQ-006 push SHALL be combinational and zero- or one-hot: it is the first set bit of push_req at or after index (rr_push+1) mod NUM_LISTS, else zero.
REQ-007 push SHALL be all-zero while full=1, even if a pop is granted in the same cycle.
REQ-008 pop SHALL be combinational and zero- or one-hot: it is the first set bit of (pop_req & ~empty) at or after index (rr_pop+1) mod NUM_LISTS, else zero.
REQ-009 A request whose list is empty SHALL be skipped, and the next eligible requester SHALL win in the same cycle.
REQ-010 Handshake: a requester's operation completes on every rising edge where its req bit and its grant bit are both 1; a held req SHALL yield one operation per granted cycle.
REQ-011 On a rising edge with a nonzero grant, the matching rr pointer SHALL load the granted index; with no grant it SHALL hold.
REQ-012 Shadow count[i] SHALL update as count[i] + push[i] - pop[i] on every edge.
REQ-013 total SHALL update as total + |push - |pop on every edge, so it tracks linked_list occupancy exactly.
REQ-014 Push and pop to the same list in one cycle SHALL be allowed when count[i] >= 1; count[i] is then unchanged.
REQ-015 Push to list i and pop from list j (i != j) in one cycle SHALL be allowed; total is then unchanged.
REQ-016 Counters SHALL never wrap: under REQ-007 and REQ-008, count[i] <= NUM_ELEMS and 0 <= total <= NUM_ELEMS.
REQ-017 Grants SHALL have zero-cycle latency from req; all state changes take effect at the next rising edge.

Reset
REQ-018 While rst=0, asynchronously:
  rr_push and rr_pop = NUM_LISTS-1, so index 0 has first priority;
  all count[i] = 0 and total = 0;
  empty = all-ones and full = 0.
REQ-019 While rst=0, push and pop SHALL be forced to zero.
REQ-020 Reset asserted mid-operation SHALL discard any in-flight grant, with no counter update on that edge.
REQ-021 The first grant after reset deassertion SHALL occur at the first rising edge following release.

Configuration
REQ-022 Macro LL_ARBITER_OCC_EN, when defined, SHALL add output port occ of width NUM_LISTS*CNT_WIDTH: the packed shadow counts, with list i at bits [CNT_WIDTH*i +: CNT_WIDTH].
REQ-023 Without LL_ARBITER_OCC_EN, port occ SHALL be absent; all other behaviour is identical.

Verification (NUM_ELEMS=4, NUM_LISTS=2)
REQ-024 Reset, then push_req=2'b11 held for 2 cycles -> push=01 then 10; rr_push ends at 1, total=2, empty=00.
REQ-025 Hold push_req=2'b01 for 5 cycles from reset -> push=01 for 4 cycles, then 00; full=1 and total=4 after the 4th edge.
REQ-026 With full=1, drive push_req=01 and pop_req=01 -> pop=01, push=00; next cycle total=3 and push=01 is granted.
REQ-027 With count[0]=0 and count[1]=2, drive pop_req=2'b11 -> pop=10 (list 0 skipped); count[1]=1 next cycle.
REQ-028 With count[0]=1, drive push_req=01 and pop_req=01 in the same cycle -> push=01 and pop=01; count[0] stays 1 and total is unchanged.
REQ-029 Assert rst=0 mid-cycle while push=01 -> push drops to 00 immediately; total=0 and empty=11; occ=0 when LL_ARBITER_OCC_EN is defined.
